axi4_lite_master_param: RTL
===========================

Name: axi4_lite_master_param

Overview:
- Parametrised single-outstanding AXI4-Lite master: one user command per transaction, translated into AXI4-Lite read or write bursts of length 1.
- Generalises the first-generation master:
  - configurable address and data width
  - user-supplied write strobes
  - AW and W channels handshake independently
  - slave response code returned to the user
  - response-phase timeout watchdog with sticky halt
- Sits between local control logic (register sequencers, DMA descriptors) and the AXI4-Lite interconnect.

Parameters:
ADDR_W, 32, address width in bits (>=12)
DATA_W, 32, data width in bits; 32 or 64 only
TIMEOUT, 1024, max cycles waiting for BVALID/RVALID; 0 disables watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
AXI_Start  in  1  command request; sampled only in S_IDLE
AXI_WriteEn  in  1  1=write, 0=read
AXI_Addr  in  ADDR_W  transaction address
AXI_WData  in  DATA_W  write data
AXI_WStrb  in  DATA_W/8  write byte strobes
AXI_RData  out  DATA_W  last read data
AXI_Resp  out  2  BRESP/RRESP of last transaction (2'b10 on timeout)
AXI_Done  out  1  one-cycle completion pulse
AXI_Busy  out  1  high whenever state != S_IDLE
AXI_Timeout  out  1  sticky watchdog flag
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR_W/3/1/1  write address channel
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR_W/3/1/1  read address channel
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
Reset:
- rst is synchronous: all state changes on the clk edge where rst=1.
- Reset values:
  - state = S_IDLE
  - all VALID/READY outputs 0
  - AXI_Done, AXI_Busy, AXI_Timeout = 0
  - AXI_Resp = 0, AXI_RData = 0
  - address/data/strobe registers = 0
  - watchdog counter = 0
- Reset mid-transaction aborts immediately; it is the only exit from S_HALT.

Fixed outputs and command capture:
- AWPROT = ARPROT = 3'b000.
- AWADDR and ARADDR both driven from the latched address register.
- Addr, WData and WStrb are latched on the S_IDLE cycle with AXI_Start=1.
- AXI_Start is ignored in every other state; no queueing.

States:
- S_IDLE:
  - on Start, go to S_WR if WriteEn=1, else S_RA.
- S_WR:
  - AWVALID = ~aw_done, WVALID = ~w_done.
  - aw_done sets on AWVALID&AWREADY; w_done sets on WVALID&WREADY.
  - Each VALID drops the cycle after its own handshake, independent of the other channel.
  - Exit to S_B once both are done, counting a handshake in the current cycle.
  - Both flags clear on exit.
- S_B:
  - BREADY=1.
  - On BVALID: AXI_Resp <= BRESP, go to S_DONE.
- S_RA:
  - ARVALID=1 until ARREADY, then go to S_R.
- S_R:
  - RREADY=1.
  - On RVALID: AXI_RData <= RDATA, AXI_Resp <= RRESP, go to S_DONE.
- S_DONE:
  - AXI_Done=1 for exactly one cycle, then S_IDLE.
- S_HALT:
  - All VALID/READY outputs 0, AXI_Busy=1, Start ignored.

Handshake rules:
- VALID is never deasserted before its READY; address, data and strobe outputs stay stable while VALID is high.
- READY-before-VALID from the slave is legal and handled.

Latency:
- With a zero-wait slave, AXI_Done is asserted 3 cycles after the Start edge, for both read and write.
- Back-to-back: the next Start is accepted on the cycle after AXI_Done, i.e. in S_IDLE.

Watchdog:
- Counter clears on entry to S_B/S_R and increments each cycle in those states without a VALID.
- If the count reaches TIMEOUT (TIMEOUT != 0):
  - AXI_Resp <= 2'b10, AXI_Timeout <= 1, AXI_Done pulses one cycle.
  - State goes to S_HALT, which prevents a late stray B/R being matched to a later command.
- Watchdog is not active in S_WR/S_RA, because AXI forbids withdrawing VALID.
- VALID arriving in the same cycle the count reaches TIMEOUT: the response wins; no timeout.
- Counter width is $clog2(TIMEOUT+1) and it saturates.

Error responses:
- SLVERR/DECERR are returned via AXI_Resp; the block does not halt.
- For a read error, AXI_RData still captures RDATA.

Test Plan:
- Zero-wait write: Addr=0x10, WData=0xDEADBEEF, WStrb=4'hF, all READY=1, BVALID next cycle, BRESP=0 -> AWVALID/WVALID high 1 cycle, AXI_Done at Start+3, AXI_Resp=0.
- Skewed write: AWREADY at cycle 1, WREADY at cycle 4 -> AWVALID drops after cycle 1, WVALID stays high through cycle 4, WDATA stable, single B accepted, Done once.
- Read with RVALID delayed 5 cycles: Addr=0x24, RDATA=0x12345678, RRESP=2'b10 -> AXI_RData=0x12345678, AXI_Resp=2'b10, Done once, AXI_Timeout=0.
- Timeout (TIMEOUT=8): write accepted, BVALID never asserted -> after 8 S_B cycles, Done pulse, Resp=2'b10, Timeout=1, Busy stays 1; a further Start produces no AW/AR; rst returns to S_IDLE with all outputs at reset values.
- Boundary: BVALID in the same cycle the count reaches TIMEOUT -> normal completion, Timeout=0; Start held high across Done -> second transaction starts only from S_IDLE; rst during S_WR -> VALIDs 0 next cycle.
- DATA_W=64: WStrb=8'h0F, WData=64'hAABBCCDD_11223344 -> WSTRB/WDATA driven unchanged; read returns full 64-bit RDATA.

Source files
------------

// File: rtl/axi4_lite_master_param.sv
// Single-outstanding AXI4-Lite master: one user command becomes one AW+W/B or AR/R exchange.
// Response phases are guarded by a watchdog; on expiry the block halts until reset.
module axi4_lite_master_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                AXI_Start,
    input  logic                AXI_WriteEn,
    input  logic [ADDR_W-1:0]   AXI_Addr,
    input  logic [DATA_W-1:0]   AXI_WData,
    input  logic [DATA_W/8-1:0] AXI_WStrb,
    output logic [DATA_W-1:0]   AXI_RData,
    output logic [1:0]          AXI_Resp,
    output logic                AXI_Done,
    output logic                AXI_Busy,
    output logic                AXI_Timeout,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_B, S_RA, S_R, S_DONE, S_HALT} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                done_q, timeout_q;
    logic [WD_W-1:0]     wd_q;

    logic aw_ok, w_ok, wd_expire;

    // A channel counts as finished if it already handshook or handshakes this cycle.
    assign aw_ok     = ~awvalid_q | M_AXI_AWREADY;
    assign w_ok      = ~wvalid_q  | M_AXI_WREADY;
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (AXI_Start) begin
                        addr_q  <= AXI_Addr;
                        wdata_q <= AXI_WData;
                        wstrb_q <= AXI_WStrb;
                        if (AXI_WriteEn) begin
                            state_q   <= S_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RA;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        state_q  <= S_B;
                        bready_q <= 1'b1;
                        wd_q     <= '0;
                    end
                end
                S_B: begin
                    if (M_AXI_BVALID) begin
                        resp_q   <= M_AXI_BRESP;
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (wd_expire) begin
                        resp_q    <= 2'b10;
                        timeout_q <= 1'b1;
                        bready_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_HALT;
                    end else if (wd_q != '1) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_RA: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (M_AXI_RVALID) begin
                        rdata_q  <= M_AXI_RDATA;
                        resp_q   <= M_AXI_RRESP;
                        rready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (wd_expire) begin
                        resp_q    <= 2'b10;
                        timeout_q <= 1'b1;
                        rready_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_HALT;
                    end else if (wd_q != '1) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                // Only reset leaves S_HALT, so a late response can never pair with a new command.
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign AXI_RData     = rdata_q;
    assign AXI_Resp      = resp_q;
    assign AXI_Done      = done_q;
    assign AXI_Busy      = (state_q != S_IDLE);
    assign AXI_Timeout   = timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
